// File: rtl/pixel_write_arbiter_if.sv
// Bundle of the client request bus and the VGA adapter write port.
// master: the drawing side (clients + clear requester); slave: the arbiter.
interface pixel_write_arbiter_if;
  logic        clear_req;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_color;
  logic [2:0]  ack;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  color;
  logic        plot;
  logic        clear_busy;
  logic        clear_done;

  modport master (
    output clear_req, req, req_x, req_y, req_color,
    input  ack, x, y, color, plot, clear_busy, clear_done
  );

  modport slave (
    input  clear_req, req, req_x, req_y, req_color,
    output ack, x, y, color, plot, clear_busy, clear_done
  );
endinterface

// File: rtl/pixel_write_arbiter.sv
// Shares the VGA adapter write port among three round-robin drawing clients.
// A full-screen clear sweep takes priority over all clients. Outputs registered.
module pixel_write_arbiter #(
  parameter int         SCREEN_W = 160,
  parameter int         SCREEN_H = 120,
  parameter logic [2:0] BG_COLOR = 3'b000
) (
  input  logic                  clk,
  input  logic                  reset,
  pixel_write_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {SEL, WRITE, CLEAR} state_t;

  localparam logic [7:0] X_LIM  = 8'(SCREEN_W);
  localparam logic [6:0] Y_LIM  = 7'(SCREEN_H);
  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  color_q, color_d;
  logic        plot_q, plot_d;
  logic [2:0]  ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  sx_q, sx_d;
  logic [6:0]  sy_q, sy_d;

  // Per-client views of the packed request fields
  logic [7:0]  cli_x     [3];
  logic [6:0]  cli_y     [3];
  logic [2:0]  cli_color [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_unpack
      assign cli_x[gi]     = bus.req_x[8*gi +: 8];
      assign cli_y[gi]     = bus.req_y[7*gi +: 7];
      assign cli_color[gi] = bus.req_color[3*gi +: 3];
    end
  endgenerate

  // Round-robin pick: first pending client in order ptr, ptr+1, ptr+2 (mod 3)
  logic [1:0] cand [3];
  logic [1:0] gnt;
  logic       found;
  always_comb begin
    cand[0] = ptr_q;
    cand[1] = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
    cand[2] = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;
    gnt     = ptr_q;
    found   = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (bus.req[cand[k]]) begin
        gnt   = cand[k];
        found = 1'b1;
      end
    end
  end

  // Next-state and registered-output computation for SEL / WRITE / CLEAR
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    plot_d  = 1'b0;
    ack_d   = 3'b000;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sx_d    = sx_q;
    sy_d    = sy_q;
    case (state_q)
      SEL: begin
        if (bus.clear_req) begin
          // Clear wins; pending client requests simply wait
          state_d = CLEAR;
          sx_d    = 8'd0;
          sy_d    = 7'd0;
          x_d     = 8'd0;
          y_d     = 7'd0;
          color_d = BG_COLOR;
          plot_d  = 1'b1;
          busy_d  = 1'b1;
        end else if (found) begin
          state_d = WRITE;
          x_d     = cli_x[gnt];
          y_d     = cli_y[gnt];
          color_d = cli_color[gnt];
          // Out-of-range pixels are acked but never reach the adapter
          plot_d  = (cli_x[gnt] < X_LIM) && (cli_y[gnt] < Y_LIM);
          ack_d   = 3'b001 << gnt;
          ptr_d   = (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
        end
      end
      WRITE: begin
        state_d = SEL;
      end
      CLEAR: begin
        if (sx_q == X_LAST && sy_q == Y_LAST) begin
          state_d = SEL;
          done_d  = 1'b1;
        end else begin
          if (sx_q == X_LAST) begin
            sx_d = 8'd0;
            sy_d = sy_q + 7'd1;
          end else begin
            sx_d = sx_q + 8'd1;
          end
          x_d     = sx_d;
          y_d     = sy_d;
          color_d = BG_COLOR;
          plot_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: state_d = SEL;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEL;
      ptr_q   <= 2'd0;
      x_q     <= 8'd0;
      y_q     <= 7'd0;
      color_q <= 3'd0;
      plot_q  <= 1'b0;
      ack_q   <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sx_q    <= 8'd0;
      sy_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      plot_q  <= plot_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.color      = color_q;
  assign bus.plot       = plot_q;
  assign bus.ack        = ack_q;
  assign bus.clear_busy = busy_q;
  assign bus.clear_done = done_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter with a scoreboard of expected writes.
module tb_pixel_write_arbiter;

  logic clk;
  logic reset;
  pixel_write_arbiter_if bus ();

  pixel_write_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ack;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: every cycle with a write strobe or ack must match the scoreboard head
  always @(posedge clk) begin
    exp_t obs, e;
    #1;
    if (bus.plot || bus.ack != 3'b000) begin
      obs = {bus.ack, bus.plot, bus.x, bus.y, bus.color, bus.clear_busy};
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_write got=%h want=none", obs);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        total++;
        assert (obs === e) else begin
          bad++;
          $error("FAIL write got ack=%b plot=%b x=%0d y=%0d c=%0d busy=%b want ack=%b plot=%b x=%0d y=%0d c=%0d busy=%b",
                 obs.ack, obs.plot, obs.x, obs.y, obs.color, obs.busy,
                 e.ack, e.plot, e.x, e.y, e.color, e.busy);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.clear_req = 1'b0;
    bus.req       = 3'b000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_client(input int i, input int px, input int py, input int pc);
    bus.req_x[8*i +: 8]     = 8'(px);
    bus.req_y[7*i +: 7]     = 7'(py);
    bus.req_color[3*i +: 3] = 3'(pc);
  endtask

  task automatic push_write(input logic [2:0] a, input logic p, input int px, input int py, input int pc);
    sb.push_back('{ack: a, plot: p, x: 8'(px), y: 7'(py), color: 3'(pc), busy: 1'b0});
  endtask

  task automatic push_sweep();
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        sb.push_back('{ack: 3'b000, plot: 1'b1, x: 8'(xx), y: 7'(yy), color: 3'b000, busy: 1'b1});
  endtask

  // Waits (bounded) for an ack pulse, then checks which client got it
  task automatic wait_ack(input string tag, input logic [2:0] want);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack == 3'b000 && n < 50);
    check(tag, 32'(bus.ack), 32'(want));
  endtask

  initial begin
    int cnt [3];
    int acks, cyc, last, plots, n, viol;
    logic [2:0] a;

    reset         = 1'b1;
    bus.clear_req = 1'b0;
    bus.req       = 3'b000;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_color = '0;

    // --- reset values ---
    do_reset();
    check("rst_plot", 32'(bus.plot), 0);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_xyc", {bus.x, bus.y, bus.color}, 0);
    check("rst_busy_done", {bus.clear_busy, bus.clear_done}, 0);

    // --- single client write, one-cycle grant latency ---
    set_client(0, 10, 20, 5);
    push_write(3'b001, 1'b1, 10, 20, 5);
    bus.req = 3'b001;
    @(negedge clk);
    check("t1_latency_ack", 32'(bus.ack), 32'(3'b001));
    bus.req = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check("t1_idle_plot", 32'(bus.plot), 0);
    check("t1_idle_ack", 32'(bus.ack), 0);
    $display("t1 single write done");

    // --- round robin with all three clients, one ack per 2 cycles ---
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cnt[i] = 0;
      set_client(i, i*20, i*10, i);
    end
    for (int k = 0; k < 6; k++)
      push_write(3'(1 << (k % 3)), 1'b1, (k%3)*20 + k/3, (k%3)*10 + k/3, ((k%3) + k/3) % 8);
    bus.req = 3'b111;
    acks = 0; cyc = 0; last = -1;
    for (int s = 0; s < 40 && acks < 6; s++) begin
      @(negedge clk);
      cyc++;
      a = bus.ack;
      if (a != 3'b000) begin
        if (last >= 0) check("t2_ack_spacing", 32'(cyc - last), 2);
        last = cyc;
        acks++;
        for (int i = 0; i < 3; i++) begin
          if (a[i]) begin
            cnt[i]++;
            set_client(i, i*20 + cnt[i], i*10 + cnt[i], i + cnt[i]);
          end
        end
        if (acks == 6) bus.req = 3'b000;
      end
    end
    check("t2_ack_count", 32'(acks), 6);
    $display("t2 round robin acks=%0d", acks);

    // --- clear beats a simultaneous request; full sweep then client1 ---
    do_reset();
    set_client(1, 30, 40, 6);
    push_sweep();
    push_write(3'b010, 1'b1, 30, 40, 6);
    bus.clear_req = 1'b1;
    bus.req       = 3'b010;
    @(negedge clk);
    bus.clear_req = 1'b0;
    plots = 0; n = 0;
    while (!bus.clear_done && n < 20000) begin
      if (bus.plot && bus.clear_busy) plots++;
      @(negedge clk);
      n++;
    end
    check("t3_sweep_len", 32'(plots), 19200);
    check("t3_done_plot", 32'(bus.plot), 0);
    check("t3_done_busy", 32'(bus.clear_busy), 0);
    @(negedge clk);
    check("t3_done_width", 32'(bus.clear_done), 0);
    check("t3_client1_ack", 32'(bus.ack), 32'(3'b010));
    bus.req = 3'b000;
    @(negedge clk);
    check("t3_sb_empty", 32'(sb.size()), 0);
    $display("t3 clear sweep plots=%0d", plots);

    // --- clipping at the screen boundary ---
    do_reset();
    set_client(2, 160, 5, 1);
    push_write(3'b100, 1'b0, 160, 5, 1);
    bus.req = 3'b100;
    wait_ack("t4_clip_x_ack", 3'b100);
    set_client(2, 7, 120, 2);
    push_write(3'b100, 1'b0, 7, 120, 2);
    wait_ack("t4_clip_y_ack", 3'b100);
    set_client(2, 159, 119, 3);
    push_write(3'b100, 1'b1, 159, 119, 3);
    wait_ack("t4_corner_ack", 3'b100);
    bus.req = 3'b000;
    @(negedge clk);
    $display("t4 clipping done");

    // --- reset in the middle of a sweep ---
    do_reset();
    push_sweep();
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    repeat (4999) @(negedge clk);
    check("t5_progress", 32'(sb.size()), 19200 - 5000);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    check("t5_plot", 32'(bus.plot), 0);
    check("t5_busy", 32'(bus.clear_busy), 0);
    check("t5_xy", {bus.x, bus.y}, 0);
    viol = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.clear_done || bus.plot || bus.clear_busy) viol++;
    end
    check("t5_no_done", 32'(viol), 0);
    set_client(2, 50, 60, 2);
    push_write(3'b100, 1'b1, 50, 60, 2);
    bus.req = 3'b100;
    wait_ack("t5_after_reset_ack", 3'b100);
    bus.req = 3'b000;
    @(negedge clk);
    $display("t5 reset mid-sweep done");

    // --- clear_req re-pulsed mid-sweep is ignored ---
    do_reset();
    push_sweep();
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    plots = 0; n = 0;
    while (!bus.clear_done && n < 20000) begin
      if (bus.plot && bus.clear_busy) plots++;
      bus.clear_req = (n == 100);
      @(negedge clk);
      n++;
    end
    bus.clear_req = 1'b0;
    check("t6_sweep_len", 32'(plots), 19200);
    viol = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.plot || bus.clear_busy) viol++;
    end
    check("t6_no_second_sweep", 32'(viol), 0);
    $display("t6 re-pulse plots=%0d", plots);

    check("final_sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
